win_scanner: RTL

Parametrised serial scanner that walks a packed vector of game-piece cells one cell per clock and reports the first run of `RUN_LEN` identical non-empty pieces. It supports a start/busy/done handshake, optional early stop, win position reporting and detection of wins by more than one player. It sits after the board-to-line flattening logic and feeds the game-over/winner display path. Lines in the packed vector are separated by empty cells.

---
 rtl/win_scanner.sv | 137 +++++++++++++
 1 files changed

// File: rtl/win_scanner.sv
// Serial scanner: walks packed board cells one per clock, reports first run of RUN_LEN equal pieces.
// Latency: NUM_CELLS+1 cycles from accepted start to done (full scan); win index k + 2 with early stop.
// Backpressure: none; start is only accepted in IDLE and ignored while busy or done.
module win_scanner #(
  parameter int NUM_CELLS = 199,
  parameter int PIECE_W   = 2,
  parameter int RUN_LEN   = 4,
  parameter int IDX_W     = $clog2(NUM_CELLS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_CELLS*PIECE_W-1:0] cells,
  input  logic                         full_scan,
  output logic                         busy,
  output logic                         done,
  output logic [PIECE_W-1:0]           winner,
  output logic [IDX_W-1:0]             win_index,
  output logic                         multi_win
);

  localparam int VEC_W = NUM_CELLS * PIECE_W;
  localparam int CNT_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] RUN_PRE  = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

  // A run length of 1 would make every single piece a win; reject it at elaboration.
  generate
    if (RUN_LEN < 2 || RUN_LEN > NUM_CELLS) begin : g_bad_run_len
      $error("win_scanner: RUN_LEN must be in 2..NUM_CELLS");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [VEC_W-1:0]   shift_q;
  logic               full_q;
  logic [IDX_W-1:0]   idx;
  logic [PIECE_W-1:0] run_piece;
  logic [CNT_W-1:0]   run_count;

  logic [PIECE_W-1:0] cur_piece;
  logic               extend;
  logic               win_evt;
  logic               stop_now;
  logic [CNT_W-1:0]   next_count;

  // Classify the cell at the top of the shift register against the current run.
  always_comb begin
    cur_piece  = shift_q[VEC_W-1 -: PIECE_W];
    extend     = (cur_piece != '0) && (cur_piece == run_piece) && (run_count != '0);
    // Only the RUN_LEN-1 -> RUN_LEN step counts, so a saturated longer run wins once.
    win_evt    = extend && (run_count == RUN_PRE);
    next_count = RUN_ONE;
    if (cur_piece == '0) begin
      next_count = '0;
    end else if (extend) begin
      next_count = (run_count == RUN_MAX) ? RUN_MAX : run_count + 1'b1;
    end
    stop_now   = (idx == LAST_IDX) || (win_evt && !full_q);
  end

  // Control FSM plus datapath; all outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      winner    <= '0;
      win_index <= '0;
      multi_win <= 1'b0;
      shift_q   <= '0;
      full_q    <= 1'b0;
      idx       <= '0;
      run_piece <= '0;
      run_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_q   <= cells;
            full_q    <= full_scan;
            idx       <= '0;
            run_piece <= '0;
            run_count <= '0;
            winner    <= '0;
            win_index <= '0;
            multi_win <= 1'b0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          shift_q   <= shift_q << PIECE_W;
          run_count <= next_count;
          if (cur_piece != '0 && !extend) begin
            run_piece <= cur_piece;
          end
          // winner is never zero once set, so zero means no win seen yet.
          if (win_evt) begin
            if (winner == '0) begin
              winner    <= cur_piece;
              win_index <= idx;
            end else if (cur_piece != winner) begin
              multi_win <= 1'b1;
            end
          end
          if (stop_now) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
